// File: rtl/nvram_upload_reader_if.sv
// Bundle of the hps_io upload signals and the NVRAM read port used by nvram_upload_reader.
// The slave modport is the reader; the master modport is the hps_io / RAM side.
interface nvram_upload_reader_if #(
    parameter int AW = 10
);
    // Handshakes:
    // - hps_io -> reader: ioctl_rd is a one-cycle strobe carrying ioctl_addr. ioctl_wait goes
    //   high the cycle after an accepted strobe and drops in the cycle ioctl_din holds the
    //   byte. Strobes seen while ioctl_wait is high are dropped.
    // - reader -> RAM: mem_rd is taken only when mem_busy is low, and mem_q is valid exactly
    //   one cycle after that accepted cycle.
    logic          ioctl_upload_req;
    logic          ioctl_upload;
    logic [7:0]    ioctl_index;
    logic          ioctl_rd;
    logic [24:0]   ioctl_addr;
    logic [7:0]    ioctl_din;
    logic          ioctl_wait;
    logic          mem_busy;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_q;

    modport slave (
        input  ioctl_upload,
        input  ioctl_index,
        input  ioctl_rd,
        input  ioctl_addr,
        input  mem_busy,
        input  mem_q,
        output ioctl_upload_req,
        output ioctl_din,
        output ioctl_wait,
        output mem_rd,
        output mem_addr
    );

    modport master (
        output ioctl_upload,
        output ioctl_index,
        output ioctl_rd,
        output ioctl_addr,
        output mem_busy,
        output mem_q,
        input  ioctl_upload_req,
        input  ioctl_din,
        input  ioctl_wait,
        input  mem_rd,
        input  mem_addr
    );
endinterface

// File: rtl/nvram_upload_reader.sv
// HPS save upload engine: requests an upload, serves ioctl byte reads from a
// 1-cycle-latency NVRAM and holds the game CPU paused while the upload runs.
module nvram_upload_reader #(
    parameter int AW    = 10,
    parameter int SIZE  = 1024,
    parameter int INDEX = 4
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic                 save_trigger,
    nvram_upload_reader_if.slave bus,
    output logic                 cpu_pause,
    output logic                 upload_done,
    output logic [2:0]           dbg_state_o
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_ARMED   = 3'd2,
        S_ISSUE   = 3'd3,
        S_CAPTURE = 3'd4
    } state_t;

    localparam logic [AW:0]   SIZE_C      = (AW + 1)'(SIZE);
    localparam logic [24:0]   SIZE_ADDR_C = 25'(SIZE);
    localparam logic [7:0]    INDEX_C     = 8'(INDEX);

    state_t        state_q;
    logic          trig_q;
    logic          upload_q;
    logic          active_q;
    logic          req_q;
    logic [7:0]    din_q;
    logic          wait_q;
    logic          issue_q;
    logic          ff_pend_q;
    logic [AW-1:0] addr_q;
    logic          pause_q;
    logic          done_q;
    logic [AW:0]   cnt_q;
    logic [AW:0]   cnt_d;

    logic active;
    logic active_rise;
    logic trig_rise;
    logic upload_fall;
    logic rd_ok;
    logic addr_oor;

    assign active      = bus.ioctl_upload && (bus.ioctl_index == INDEX_C);
    assign active_rise = active && !active_q;
    assign trig_rise   = save_trigger && !trig_q;
    assign upload_fall = upload_q && !bus.ioctl_upload;
    // A strobe arriving while a read is still outstanding is a protocol violation and dropped.
    assign rd_ok       = bus.ioctl_rd && active && !wait_q;
    assign addr_oor    = bus.ioctl_addr >= SIZE_ADDR_C;
    assign cnt_d       = (cnt_q == SIZE_C) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            trig_q    <= 1'b0;
            upload_q  <= 1'b0;
            active_q  <= 1'b0;
            req_q     <= 1'b0;
            din_q     <= 8'h00;
            wait_q    <= 1'b0;
            issue_q   <= 1'b0;
            ff_pend_q <= 1'b0;
            addr_q    <= '0;
            pause_q   <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            trig_q   <= save_trigger;
            upload_q <= bus.ioctl_upload;
            active_q <= active;
            req_q    <= 1'b0;
            done_q   <= 1'b0;

            unique case (state_q)
                S_IDLE: begin
                    // An upload started by hps_io on its own is served like a requested one.
                    if (active_rise) begin
                        state_q <= S_ARMED;
                        pause_q <= 1'b1;
                    end else if (trig_rise && !bus.ioctl_upload) begin
                        state_q <= S_REQ;
                        req_q   <= 1'b1;
                    end
                end

                S_REQ: begin
                    state_q <= S_ARMED;
                end

                S_ARMED, S_ISSUE, S_CAPTURE: begin
                    if (upload_fall) begin
                        state_q   <= S_IDLE;
                        wait_q    <= 1'b0;
                        pause_q   <= 1'b0;
                        issue_q   <= 1'b0;
                        ff_pend_q <= 1'b0;
                        done_q    <= (cnt_q == SIZE_C);
                        cnt_q     <= '0;
                    end else if (state_q == S_ARMED) begin
                        pause_q <= active;
                        if (ff_pend_q) begin
                            din_q     <= 8'hFF;
                            wait_q    <= 1'b0;
                            ff_pend_q <= 1'b0;
                        end else if (rd_ok) begin
                            wait_q <= 1'b1;
                            addr_q <= bus.ioctl_addr[AW-1:0];
                            if (addr_oor) begin
                                ff_pend_q <= 1'b1;
                            end else begin
                                state_q <= S_ISSUE;
                                issue_q <= 1'b1;
                            end
                        end
                    end else if (state_q == S_ISSUE) begin
                        if (!bus.mem_busy) begin
                            issue_q <= 1'b0;
                            state_q <= S_CAPTURE;
                        end
                    end else begin
                        din_q   <= bus.mem_q;
                        wait_q  <= 1'b0;
                        cnt_q   <= cnt_d;
                        state_q <= S_ARMED;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // The read enable is gated live by mem_busy so the request is only taken on a free cycle.
    assign bus.mem_rd           = issue_q && !bus.mem_busy;
    assign bus.mem_addr         = addr_q;
    assign bus.ioctl_upload_req = req_q;
    assign bus.ioctl_din        = din_q;
    assign bus.ioctl_wait       = wait_q;
    assign cpu_pause            = pause_q;
    assign upload_done          = done_q;
    assign dbg_state_o          = state_q;
endmodule

// File: tb/tb_nvram_upload_reader.sv
// Bench for nvram_upload_reader: RAM array, randomized reads and a byte/latency model
// derived from the read-back rules (in range -> RAM byte, out of range -> 8'hFF).
module tb_nvram_upload_reader;
    localparam int AW    = 10;
    localparam int SIZE  = 1024;
    localparam int INDEX = 4;

    logic       clk_sys = 1'b0;
    logic       reset_n = 1'b0;
    logic       save_trigger = 1'b0;
    logic       cpu_pause;
    logic       upload_done;
    logic [2:0] dbg_state;

    nvram_upload_reader_if #(.AW(AW)) bus ();

    nvram_upload_reader #(.AW(AW), .SIZE(SIZE), .INDEX(INDEX)) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .save_trigger (save_trigger),
        .bus          (bus),
        .cpu_pause    (cpu_pause),
        .upload_done  (upload_done),
        .dbg_state_o  (dbg_state)
    );

    always #5 clk_sys = ~clk_sys;

    logic [7:0] ram [SIZE];
    int         req_cnt  = 0;
    int         done_cnt = 0;
    int         mrd_cnt  = 0;

    always @(posedge clk_sys) begin
        if (bus.mem_rd) bus.mem_q <= ram[bus.mem_addr];
        if (bus.mem_rd) mrd_cnt <= mrd_cnt + 1;
        if (bus.ioctl_upload_req) req_cnt <= req_cnt + 1;
        if (upload_done) done_cnt <= done_cnt + 1;
    end

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q [$];
    logic [7:0] last_exp = 8'h00;
    int         served = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_sys);
        #1;
    endtask

    function automatic logic [7:0] model_byte(input logic [24:0] a);
        logic [AW-1:0] idx;
        idx = a[AW-1:0];
        return (a < 25'(SIZE)) ? ram[idx] : 8'hFF;
    endfunction

    task automatic reset_checks(input string tag);
        chk({tag, "_req"},   32'(bus.ioctl_upload_req), 32'd0);
        chk({tag, "_din"},   32'(bus.ioctl_din), 32'd0);
        chk({tag, "_wait"},  32'(bus.ioctl_wait), 32'd0);
        chk({tag, "_memrd"}, 32'(bus.mem_rd), 32'd0);
        chk({tag, "_maddr"}, 32'(bus.mem_addr), 32'd0);
        chk({tag, "_pause"}, 32'(cpu_pause), 32'd0);
        chk({tag, "_done"},  32'(upload_done), 32'd0);
        chk({tag, "_state"}, 32'(dbg_state), 32'd0);
    endtask

    // One read: strobe at cycle T, busy cycles during the RAM access, optional extra strobe
    // while the read is outstanding (must be ignored).
    task automatic do_read(input logic [24:0] addr, input int busy, input bit dup);
        int lat;
        int base;
        int exp_lat;
        bit in_rng;
        in_rng  = (addr < 25'(SIZE));
        exp_q.push_back(model_byte(addr));
        exp_lat = in_rng ? 3 + busy : 2;
        base    = mrd_cnt;
        lat     = 0;
        bus.ioctl_rd   = 1'b1;
        bus.ioctl_addr = addr;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            tick;
            bus.ioctl_rd = dup && (k == 1);
            if (dup && k == 1) bus.ioctl_addr = 25'h1FFFFFF;
            bus.mem_busy = in_rng && (k <= busy);
            #1;
            if (k == 1) chk("wait_hi", 32'(bus.ioctl_wait), 32'd1);
            if (in_rng && k == busy + 1) begin
                chk("mem_rd", 32'(bus.mem_rd), 32'd1);
                chk("mem_addr", 32'(bus.mem_addr), 32'(addr[AW-1:0]));
            end
            if (!bus.ioctl_wait) lat = k;
        end
        bus.mem_busy = 1'b0;
        chk("latency", 32'(lat), 32'(exp_lat));
        last_exp = exp_q.pop_front();
        chk("din", 32'(bus.ioctl_din), 32'(last_exp));
        chk("mem_rd_count", 32'(mrd_cnt - base), 32'(in_rng));
        chk("pause_on", 32'(cpu_pause), 32'd1);
        if (in_rng) served++;
    endtask

    task automatic end_upload(input bit exp_done);
        int d0;
        d0 = done_cnt;
        bus.ioctl_upload = 1'b0;
        tick;
        #1;
        chk("done_pulse", 32'(upload_done), 32'(exp_done));
        chk("pause_off", 32'(cpu_pause), 32'd0);
        chk("end_state", 32'(dbg_state), 32'd0);
        chk("end_wait", 32'(bus.ioctl_wait), 32'd0);
        tick;
        chk("done_count", 32'(done_cnt - d0), 32'(exp_done));
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         r0;
        int         m0;
        int         d0;
        logic [24:0] a;

        bus.ioctl_upload = 1'b0;
        bus.ioctl_index  = 8'(INDEX);
        bus.ioctl_rd     = 1'b0;
        bus.ioctl_addr   = '0;
        bus.mem_busy     = 1'b0;
        bus.mem_q        = 8'h00;
        for (int i = 0; i < SIZE; i++) ram[i] = 8'($urandom_range(0, 255));
        ram[5] = 8'hA5;

        repeat (4) tick;
        reset_checks("rst0");
        reset_n = 1'b1;
        tick;

        // Requested upload
        r0 = req_cnt;
        save_trigger = 1'b1;
        tick;
        chk("req_pulse", 32'(bus.ioctl_upload_req), 32'd1);
        tick;
        chk("armed_state", 32'(dbg_state), 32'd2);
        chk("req_low", 32'(bus.ioctl_upload_req), 32'd0);
        bus.ioctl_upload = 1'b1;
        #1;
        chk("pause_pre", 32'(cpu_pause), 32'd0);
        tick;
        chk("pause_rise", 32'(cpu_pause), 32'd1);
        served = 0;
        save_trigger = 1'b0;
        tick;
        save_trigger = 1'b1;
        tick;
        tick;
        chk("req_count", 32'(req_cnt - r0), 32'd1);

        do_read(25'd5, 0, 1'b0);
        chk("din_a5", 32'(bus.ioctl_din), 32'hA5);
        do_read(25'd5, 3, 1'b0);
        do_read(25'd1024, 0, 1'b0);
        do_read(25'h1000005, 0, 1'b0);
        do_read(25'd1023, 0, 1'b0);
        do_read(25'd20, 1, 1'b1);
        do_read(25'd1024, 0, 1'b1);

        // Wrong index strobe
        m0 = mrd_cnt;
        bus.ioctl_index = 8'd3;
        bus.ioctl_rd    = 1'b1;
        bus.ioctl_addr  = 25'd7;
        tick;
        bus.ioctl_rd    = 1'b0;
        bus.ioctl_index = 8'(INDEX);
        #1;
        chk("idx_wait", 32'(bus.ioctl_wait), 32'd0);
        repeat (3) tick;
        chk("idx_din", 32'(bus.ioctl_din), 32'(last_exp));
        chk("idx_memrd", 32'(mrd_cnt - m0), 32'd0);
        chk("idx_state", 32'(dbg_state), 32'd2);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) a = 25'($urandom_range(SIZE, 32'h1FFFFFF));
            else a = 25'($urandom_range(0, SIZE - 1));
            do_read(a, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < SIZE; i++) do_read(25'(i), int'($urandom_range(0, 2)), 1'b0);
        save_trigger = 1'b0;
        chk("req_count_end", 32'(req_cnt - r0), 32'd1);
        end_upload(served >= SIZE);

        // External upload aborted during ISSUE after 10 bytes
        bus.ioctl_upload = 1'b1;
        tick;
        #1;
        chk("ext_state", 32'(dbg_state), 32'd2);
        chk("ext_pause", 32'(cpu_pause), 32'd1);
        served = 0;
        for (int i = 0; i < 10; i++) do_read(25'($urandom_range(0, SIZE - 1)), 0, 1'b0);
        d0 = done_cnt;
        bus.ioctl_rd   = 1'b1;
        bus.ioctl_addr = 25'($urandom_range(0, SIZE - 1));
        tick;
        bus.ioctl_rd = 1'b0;
        bus.mem_busy = 1'b1;
        #1;
        chk("abort_in_issue", 32'(dbg_state), 32'd3);
        bus.ioctl_upload = 1'b0;
        tick;
        bus.mem_busy = 1'b0;
        m0 = mrd_cnt;
        #1;
        chk("abort_state", 32'(dbg_state), 32'd0);
        chk("abort_wait", 32'(bus.ioctl_wait), 32'd0);
        chk("abort_pause", 32'(cpu_pause), 32'd0);
        chk("abort_memrd", 32'(bus.mem_rd), 32'd0);
        chk("abort_done", 32'(upload_done), 32'd0);
        repeat (3) tick;
        chk("abort_done_cnt", 32'(done_cnt - d0), 32'd0);
        chk("abort_memrd_cnt", 32'(mrd_cnt - m0), 32'd0);

        // Reset while a read sits in ISSUE
        bus.ioctl_upload = 1'b1;
        tick;
        tick;
        bus.ioctl_rd   = 1'b1;
        bus.ioctl_addr = 25'd9;
        tick;
        bus.ioctl_rd = 1'b0;
        bus.mem_busy = 1'b1;
        tick;
        reset_n = 1'b0;
        bus.ioctl_upload = 1'b0;
        repeat (4) tick;
        reset_checks("rst_mid");
        reset_n = 1'b1;
        bus.mem_busy = 1'b0;
        m0 = mrd_cnt;
        repeat (5) tick;
        chk("post_rst_memrd", 32'(mrd_cnt - m0), 32'd0);
        chk("post_rst_state", 32'(dbg_state), 32'd0);
        chk("post_rst_wait", 32'(bus.ioctl_wait), 32'd0);

        // Trigger edge while some other upload runs is ignored
        bus.ioctl_index  = 8'd3;
        bus.ioctl_upload = 1'b1;
        tick;
        r0 = req_cnt;
        save_trigger = 1'b1;
        repeat (3) tick;
        chk("busy_trig_req", 32'(req_cnt - r0), 32'd0);
        chk("busy_trig_state", 32'(dbg_state), 32'd0);
        bus.ioctl_upload = 1'b0;
        save_trigger = 1'b0;
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/nvram_upload_reader.md
# nvram_upload_reader

Read-back engine for HPS save uploads: the reverse of the ROM/DIP download path. It requests an upload from hps_io, serves byte reads strobed by hps_io out of a 1-cycle-latency on-chip RAM (hiscore/NVRAM), and freezes the game CPU for the duration of the upload. It sits between hps_io and the core's NVRAM port in the top level, clocked by clk_sys.

## Interface

Parameters:
- AW, 10, NVRAM address width
- SIZE, 1024, number of valid bytes; reads at addr >= SIZE return 8'hFF
- INDEX, 4, ioctl_index value this block answers to

Ports:
- clk_sys  in  1  system clock; all logic on rising edge
- reset_n  in  1  reset, synchronous, active-low
- save_trigger  in  1  level from OSD status bit; rising edge requests a save
- ioctl_upload_req  out  1  one-cycle pulse to hps_io requesting upload
- ioctl_upload  in  1  hps_io upload in progress
- ioctl_index  in  8  current transfer index
- ioctl_rd  in  1  one-cycle read strobe from hps_io
- ioctl_addr  in  25  byte address accompanying ioctl_rd
- ioctl_din  out  8  read data to hps_io
- ioctl_wait  out  1  high while a read is outstanding
- mem_busy  in  1  NVRAM port owned by the CPU this cycle
- mem_rd  out  1  NVRAM read enable
- mem_addr  out  AW  NVRAM address
- mem_q  in  8  NVRAM data, valid exactly one cycle after an accepted mem_rd
- cpu_pause  out  1  freeze request to the game CPU
- upload_done  out  1  one-cycle pulse when upload ends after SIZE bytes were served

## Operation

- active = ioctl_upload && ioctl_index == INDEX.
- FSM states: IDLE, REQ, ARMED, ISSUE, CAPTURE.
- IDLE: save_trigger rising edge (registered previous value) with !ioctl_upload -> REQ. Edge is ignored while ioctl_upload is high.
- REQ: ioctl_upload_req = 1 for this single cycle -> ARMED.
- ARMED: cpu_pause = active. On ioctl_rd && active: latch ioctl_addr, assert ioctl_wait.
  - If latched addr >= SIZE (full 25-bit compare): ioctl_din <= 8'hFF next cycle, stay ARMED, ioctl_wait drops the same cycle ioctl_din updates.
  - Else -> ISSUE.
- ISSUE: mem_addr = latched addr[AW-1:0]; mem_rd = !mem_busy. Stays in ISSUE while mem_busy; accepted cycle -> CAPTURE.
- CAPTURE: ioctl_din <= mem_q, ioctl_wait <= 0, byte counter += 1 (saturates at SIZE), -> ARMED.
- ioctl_rd while ioctl_wait is high is ignored (protocol violation; no state change).
- ioctl_rd with ioctl_index != INDEX is ignored.
- Falling edge of ioctl_upload in ARMED/ISSUE/CAPTURE: abort to IDLE, ioctl_wait <= 0, cpu_pause <= 0, mem_rd <= 0; upload_done pulses one cycle iff byte counter == SIZE; counter cleared.
- Upload started by hps_io without a prior request (ARMED not reached via REQ): IDLE also goes to ARMED when active rises, so external saves are served identically.
- Counter width AW+1 bits.

## Timing

- Reset (reset_n low at a clock edge): state IDLE, ioctl_upload_req 0, ioctl_din 8'h00, ioctl_wait 0, mem_rd 0, mem_addr 0, cpu_pause 0, upload_done 0, counter 0, save_trigger history 0. Reset mid-read discards the read.
- ioctl_wait is registered: high in the cycle after ioctl_rd, low in the cycle ioctl_din holds new data.
- In-range latency, mem_busy low: ioctl_rd at cycle T -> mem_rd at T+1 -> ioctl_din valid and ioctl_wait low at T+3. Each mem_busy cycle during ISSUE adds one cycle.
- Out-of-range latency: ioctl_din = 8'hFF and ioctl_wait low at T+2.
- cpu_pause registered: rises the cycle after active rises, falls the cycle after ioctl_upload falls.
- ioctl_din holds its last value between reads.

## Test plan

- Reset: hold reset_n low 4 cycles mid-ISSUE -> all outputs at reset values, state IDLE, no mem_rd afterwards.
- Request: save_trigger 0->1 while idle -> exactly one ioctl_upload_req pulse; trigger held high or re-raised during upload -> no further pulses.
- Read path: RAM[0x005]=8'hA5, upload INDEX=4, ioctl_rd addr 5 -> mem_rd/mem_addr 5 at T+1, ioctl_din 8'hA5 and ioctl_wait low at T+3; cpu_pause high throughout.
- Contention: same read with mem_busy high 3 cycles -> mem_rd only on first non-busy cycle, data at T+6.
- Boundary: ioctl_rd addr 1024 and addr 25'h1000005 -> 8'hFF at T+2, no mem_rd; ioctl_index 3 with ioctl_rd -> no response.
- Completion/abort: 1024 sequential reads then ioctl_upload low -> upload_done pulse, cpu_pause low next cycle; repeat with upload dropped after 10 bytes during ISSUE -> no upload_done, ioctl_wait 0, FSM IDLE.
